// File: rtl/trap_sequencer.sv
// trap_sequencer: arbitrates synchronous exceptions, MRET/SRET and interrupts,
// issues one-cycle pulses to the CSR/exception handler, waits for its redirect
// strobe and hands the target PC back to the control FSM. Also owns WFI stall.
module trap_sequencer #(
    parameter int WFI_TIMEOUT = 0,  // 0 = WFI waits for an interrupt forever
    parameter int SEL_TIMEOUT = 7   // WAIT cycles tolerated before proto_err
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        instr_boundary,
    input  logic        exc_valid,
    input  logic [4:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        mret_req,
    input  logic        sret_req,
    input  logic        wfi_req,
    input  logic [31:0] cur_pc,
    input  logic [3:0]  irq_pending,
    input  logic        exception_select,
    input  logic [31:0] exception_next_pc,
    output logic        exception_event,
    output logic        mret,
    output logic        sret,
    output logic [31:0] cause,
    output logic [31:0] pc,
    output logic [31:0] badaddr,
    output logic        trap_ack,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        wfi_done,
    output logic        busy,
    output logic        proto_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_WFI
    } state_t;

    localparam int          CNT_W   = 16;
    localparam logic [CNT_W-1:0] SEL_LIM = CNT_W'(SEL_TIMEOUT);
    localparam logic [CNT_W-1:0] WFI_LIM = CNT_W'(WFI_TIMEOUT - 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;

    logic        exception_event_d, mret_d, sret_d, trap_ack_d;
    logic        redirect_valid_d, wfi_done_d, busy_d, proto_err_d;
    logic [31:0] cause_d, pc_d, badaddr_d, redirect_pc_d;

    logic        irq_any;
    logic [3:0]  irq_code;
    logic        wfi_expired;

    // Interrupt code selection: MSI(3) > MTI(7) > SSI(1) > STI(5).
    // Bit order of irq_pending is {MTIP, STIP, MSIP, SSIP}.
    always_comb begin
        irq_any = |irq_pending;
        if (irq_pending[1])      irq_code = 4'd3;
        else if (irq_pending[3]) irq_code = 4'd7;
        else if (irq_pending[0]) irq_code = 4'd1;
        else                     irq_code = 4'd5;
    end

    assign wfi_expired = (WFI_TIMEOUT != 0) && (cnt == WFI_LIM);

    // Next-state and next-output logic; every output is the registered copy.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d           = state;
        exception_event_d = 1'b0;
        mret_d            = 1'b0;
        sret_d            = 1'b0;
        trap_ack_d        = 1'b0;
        redirect_valid_d  = 1'b0;
        wfi_done_d        = 1'b0;
        proto_err_d       = proto_err;
        cause_d           = cause;
        pc_d              = pc;
        badaddr_d         = badaddr;
        redirect_pc_d     = redirect_pc;

        unique case (state)
            S_IDLE: begin
                if (exc_valid) begin
                    exception_event_d = 1'b1;
                    trap_ack_d        = 1'b1;
                    cause_d           = {27'b0, exc_cause};
                    pc_d              = exc_pc;
                    badaddr_d         = exc_tval;
                    state_d           = S_ISSUE;
                end else if (mret_req) begin
                    mret_d     = 1'b1;
                    trap_ack_d = 1'b1;
                    state_d    = S_ISSUE;
                end else if (sret_req) begin
                    sret_d     = 1'b1;
                    trap_ack_d = 1'b1;
                    state_d    = S_ISSUE;
                end else if (instr_boundary && irq_any) begin
                    exception_event_d = 1'b1;
                    trap_ack_d        = 1'b1;
                    cause_d           = {1'b1, 27'b0, irq_code};
                    pc_d              = cur_pc;
                    badaddr_d         = 32'b0;
                    state_d           = S_ISSUE;
                end else if (wfi_req && !wfi_done) begin
                    // wfi_req is still held during the wfi_done cycle; the
                    // guard keeps that same request from re-entering WFI.
                    if (irq_any) wfi_done_d = 1'b1;
                    else         state_d    = S_WFI;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (exception_select) begin
                    redirect_pc_d    = exception_next_pc;
                    redirect_valid_d = 1'b1;
                    state_d          = S_DONE;
                end else if (cnt >= SEL_LIM) begin
                    proto_err_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_WFI: begin
                if (irq_any || exc_valid || wfi_expired) begin
                    wfi_done_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);

        // Per-state cycle counter: cleared on entry, saturating while resident.
        if (state_d != state)  cnt_d = '0;
        else if (&cnt)         cnt_d = cnt;
        else                   cnt_d = cnt + 1'b1;
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from pre-edge values.
        if (!resetn) begin
            state           <= S_IDLE;
            cnt             <= '0;
            exception_event <= 1'b0;
            mret            <= 1'b0;
            sret            <= 1'b0;
            trap_ack        <= 1'b0;
            redirect_valid  <= 1'b0;
            wfi_done        <= 1'b0;
            busy            <= 1'b0;
            proto_err       <= 1'b0;
            cause           <= 32'b0;
            pc              <= 32'b0;
            badaddr         <= 32'b0;
            redirect_pc     <= 32'b0;
        end else begin
            state           <= state_d;
            cnt             <= cnt_d;
            exception_event <= exception_event_d;
            mret            <= mret_d;
            sret            <= sret_d;
            trap_ack        <= trap_ack_d;
            redirect_valid  <= redirect_valid_d;
            wfi_done        <= wfi_done_d;
            busy            <= busy_d;
            proto_err       <= proto_err_d;
            cause           <= cause_d;
            pc              <= pc_d;
            badaddr         <= badaddr_d;
            redirect_pc     <= redirect_pc_d;
        end
    end

endmodule
